// File: rtl/chacha20_pkg.sv
`default_nettype none
//==============================================================================
// Package  : chacha20_pkg
// Brief    : Shared constants, widths and FSM encoding for the ChaCha20
//            keystream controller slice.
// Revision : 1.0 - initial release
//==============================================================================
package chacha20_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = 4;

    // "expand 32-byte k" sigma constants, state words 0..3
    localparam logic [WORD_W-1:0] CHACHA_CONST0 = 32'h6170_7865;
    localparam logic [WORD_W-1:0] CHACHA_CONST1 = 32'h3320_646e;
    localparam logic [WORD_W-1:0] CHACHA_CONST2 = 32'h7962_2d32;
    localparam logic [WORD_W-1:0] CHACHA_CONST3 = 32'h6b20_6574;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chacha20_keystream_if.sv
`default_nettype none
//==============================================================================
// Interface : chacha20_keystream_if
// Brief     : 32-bit keystream word stream with valid/ready handshake.
// Revision  : 1.0 - initial release
//==============================================================================
interface chacha20_keystream_if;
    import chacha20_pkg::*;

    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );

endinterface
`default_nettype wire

// File: rtl/chacha20_word_serialiser.sv
`default_nettype none
//==============================================================================
// Module   : chacha20_word_serialiser
// Brief    : Holds one 512-bit keystream block and presents it as sixteen
//            32-bit words, word 0 first, over valid/ready.
// Revision : 1.0 - initial release
//==============================================================================
module chacha20_word_serialiser
    import chacha20_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    input  logic               flush,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               last_accept
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS_PER_BLOCK - 1);

    logic [BLOCK_W-1:0] r_buffer;
    logic [IDX_W-1:0]   r_index;
    logic               r_valid;
    logic               w_accept;
    logic [8:0]         w_base;

    assign w_accept    = r_valid && word_ready;
    assign last_accept = w_accept && (r_index == c_last_idx);
    // Word index times 32 gives the bit offset of the current word.
    assign w_base      = {r_index, 5'b00000};
    assign word_out    = r_buffer[w_base +: WORD_W];
    assign word_valid  = r_valid;

    // Buffer/index/valid: flush empties, load refills (even on the last
    // handshake so valid never drops between back-to-back blocks).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_buffer <= '0;
            r_index  <= '0;
            r_valid  <= 1'b0;
        end else if (flush) begin
            r_index  <= '0;
            r_valid  <= 1'b0;
        end else if (load) begin
            r_buffer <= load_data;
            r_index  <= '0;
            r_valid  <= 1'b1;
        end else if (w_accept) begin
            r_index <= r_index + 1'b1;
            if (r_index == c_last_idx) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chacha20_keystream_controller.sv
`default_nettype none
//==============================================================================
// Module   : chacha20_keystream_controller
// Brief    : Builds the ChaCha20 input state from seed and block counter,
//            launches chacha20_block, captures results and streams them out
//            while the next block computes.
// Revision : 1.0 - initial release
//==============================================================================
module chacha20_keystream_controller
    import chacha20_pkg::*;
#(
    parameter logic [WORD_W-1:0] COUNTER_INIT = 32'd0
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [255:0]       key,
    input  logic [95:0]        nonce,
    input  logic               seed_load,
    input  logic               enable,
    chacha20_keystream_if.master stream,
    output logic               exhausted,
    output logic [BLOCK_W-1:0] block_round_input,
    output logic               block_start,
    input  logic               block_finished,
    input  logic [BLOCK_W-1:0] block_round_output
);

    state_t            r_state;
    state_t            w_next_state;
    logic [255:0]      r_key;
    logic [95:0]       r_nonce;
    logic [255:0]      r_pend_key;
    logic [95:0]       r_pend_nonce;
    logic              r_reseed_pending;
    logic [WORD_W-1:0] r_counter;
    logic              r_exhausted;
    logic              r_discard;
    logic              w_capture;
    logic              w_last_accept;
    logic              w_word_valid;

    // State words 0-3 constants, 4-11 key, 12 counter, 13-15 nonce; all from
    // registers so the block core sees a steady input while it runs.
    assign block_round_input = {r_nonce, r_counter, r_key,
                                CHACHA_CONST3, CHACHA_CONST2,
                                CHACHA_CONST1, CHACHA_CONST0};
    assign exhausted         = r_exhausted;
    assign stream.word_valid = w_word_valid;

    // FSM state register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, launch and capture decisions.
    always_comb begin
        w_next_state = r_state;
        block_start  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !r_exhausted && !r_reseed_pending && block_finished) begin
                    block_start  = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (block_finished) begin
                    // A reseed during (or on the last cycle of) the block
                    // makes its result stale.
                    w_next_state = (r_discard || seed_load) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (seed_load) begin
                    w_next_state = ST_IDLE;
                end else if (!w_word_valid || w_last_accept) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Seed staging, active seed, block counter and wrap flag.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_key            <= '0;
            r_nonce          <= '0;
            r_pend_key       <= '0;
            r_pend_nonce     <= '0;
            r_reseed_pending <= 1'b0;
            r_counter        <= COUNTER_INIT;
            r_exhausted      <= 1'b0;
        end else if (seed_load) begin
            r_pend_key       <= key;
            r_pend_nonce     <= nonce;
            r_reseed_pending <= 1'b1;
        end else if ((r_state == ST_IDLE) && r_reseed_pending) begin
            r_key            <= r_pend_key;
            r_nonce          <= r_pend_nonce;
            r_counter        <= COUNTER_INIT;
            r_exhausted      <= 1'b0;
            r_reseed_pending <= 1'b0;
        end else if (w_capture) begin
            if (r_counter == {WORD_W{1'b1}}) begin
                r_exhausted <= 1'b1;
            end else begin
                r_counter <= r_counter + 1'b1;
            end
        end
    end

    // Discard flag: marks an in-flight block (or one launching this cycle)
    // as stale after a reseed; consumed when that block finishes.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_discard <= 1'b0;
        end else if ((r_state == ST_BUSY) && block_finished) begin
            r_discard <= 1'b0;
        end else if (seed_load && ((r_state == ST_BUSY) || block_start)) begin
            r_discard <= 1'b1;
        end
    end

    chacha20_word_serialiser u_ser (
        .clock       (clock),
        .clear       (clear),
        .flush       (seed_load),
        .load        (w_capture),
        .load_data   (block_round_output),
        .word_out    (stream.word_out),
        .word_valid  (w_word_valid),
        .word_ready  (stream.word_ready),
        .last_accept (w_last_accept)
    );

endmodule
`default_nettype wire

// File: tb/tb_chacha20_keystream_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_chacha20_keystream_controller
// Brief    : Bench for the keystream controller: behavioural chacha20_block,
//            word-stream scoreboard, directed + random-backpressure steps.
// Revision : 1.0 - initial release
//==============================================================================
module tb_chacha20_keystream_controller;
    import chacha20_pkg::*;

    logic         clock = 1'b0;
    logic         clear;
    logic [255:0] key       [2];
    logic [95:0]  nonce     [2];
    logic         seed_load [2];
    logic         enable    [2];
    logic         ready     [2];
    logic         exhausted [2];
    logic         bstart    [2];
    logic         bfin      [2];
    logic [511:0] bri       [2];
    logic [511:0] bro       [2];
    logic [511:0] lat       [2];
    int           cnt       [2];
    logic         valid     [2];
    logic [31:0]  word      [2];

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard state per DUT
    logic [255:0] m_key   [2];
    logic [95:0]  m_nonce [2];
    logic [31:0]  m_ctr   [2];
    logic [511:0] m_blk   [2];
    int           m_idx   [2];
    int           m_words [2];
    int           m_starts[2];
    logic         m_done  [2];

    always #5 clock = ~clock;

    chacha20_keystream_if sa();
    chacha20_keystream_if sb();

    assign sa.word_ready = ready[0];
    assign sb.word_ready = ready[1];
    assign valid[0] = sa.word_valid;
    assign valid[1] = sb.word_valid;
    assign word[0]  = sa.word_out;
    assign word[1]  = sb.word_out;

    chacha20_keystream_controller #(.COUNTER_INIT(32'd1)) dut_a (
        .clock(clock), .clear(clear), .key(key[0]), .nonce(nonce[0]),
        .seed_load(seed_load[0]), .enable(enable[0]), .stream(sa),
        .exhausted(exhausted[0]), .block_round_input(bri[0]),
        .block_start(bstart[0]), .block_finished(bfin[0]),
        .block_round_output(bro[0])
    );

    chacha20_keystream_controller #(.COUNTER_INIT(32'hFFFF_FFFE)) dut_b (
        .clock(clock), .clear(clear), .key(key[1]), .nonce(nonce[1]),
        .seed_load(seed_load[1]), .enable(enable[1]), .stream(sb),
        .exhausted(exhausted[1]), .block_round_input(bri[1]),
        .block_start(bstart[1]), .block_finished(bfin[1]),
        .block_round_output(bro[1])
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // ChaCha20 block function: 20 rounds then add the input state.
    function automatic logic [511:0] chacha_block(input logic [511:0] st);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] r;
        logic [511:0] o;
        int           qi [8][4];
        qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        for (int i = 0; i < 16; i++) begin
            s[i] = st[32*i +: 32];
            x[i] = s[i];
        end
        for (int rd = 0; rd < 10; rd++) begin
            for (int q = 0; q < 8; q++) begin
                r = qr(x[qi[q][0]], x[qi[q][1]], x[qi[q][2]], x[qi[q][3]]);
                x[qi[q][0]] = r[127:96];
                x[qi[q][1]] = r[95:64];
                x[qi[q][2]] = r[63:32];
                x[qi[q][3]] = r[31:0];
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
        return o;
    endfunction

    function automatic logic [511:0] build_state(input logic [255:0] k,
                                                 input logic [31:0] ctr,
                                                 input logic [95:0] n);
        logic [31:0]  w [16];
        logic [511:0] o;
        w[0] = 32'h61707865; w[1] = 32'h3320646e;
        w[2] = 32'h79622d32; w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) w[4+i] = k[32*i +: 32];
        w[12] = ctr;
        for (int i = 0; i < 3; i++) w[13+i] = n[32*i +: 32];
        for (int i = 0; i < 16; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    function automatic logic [31:0] init_of(input int u);
        return (u == 0) ? 32'd1 : 32'hFFFF_FFFE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int u, input logic [255:0] k, input logic [95:0] n);
        m_key[u]   = k;
        m_nonce[u] = n;
        m_ctr[u]   = init_of(u);
        m_idx[u]   = 0;
        m_done[u]  = 1'b0;
        m_blk[u]   = chacha_block(build_state(k, init_of(u), n));
    endtask

    task automatic nclk();
        @(negedge clock);
        #1;
    endtask

    task automatic pclk();
        @(posedge clock);
        #1;
    endtask

    // Behavioural chacha20_block with a random latency per block.
    always @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int u = 0; u < 2; u++) begin
                bfin[u] <= 1'b1;
                bro[u]  <= '0;
                cnt[u]  <= 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (bfin[u] && bstart[u]) begin
                    lat[u]  <= bri[u];
                    bfin[u] <= 1'b0;
                    cnt[u]  <= int'($urandom_range(3, 18));
                end else if (!bfin[u]) begin
                    if (cnt[u] == 0) begin
                        bro[u]  <= chacha_block(lat[u]);
                        bfin[u] <= 1'b1;
                    end else begin
                        cnt[u] <= cnt[u] - 1;
                    end
                end
            end
        end
    end

    // Stream scoreboard and input-stability monitor.
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (clear) begin
                model_reset(u, '0, '0);
            end else begin
                if (bstart[u]) m_starts[u]++;
                if (!bfin[u]) chk("input_stable", 32'(bri[u] === lat[u]), 32'd1);
                if (valid[u] && ready[u]) begin
                    if (m_done[u]) begin
                        chk("word_after_exhaust", 32'(valid[u]), 32'd0);
                    end else begin
                        chk((u == 0) ? "word_a" : "word_b", word[u], m_blk[u][32*m_idx[u] +: 32]);
                        m_idx[u]++;
                        m_words[u]++;
                        if (m_idx[u] == 16) begin
                            m_idx[u] = 0;
                            if (m_ctr[u] == 32'hFFFF_FFFF) begin
                                m_done[u] = 1'b1;
                            end else begin
                                m_ctr[u] = m_ctr[u] + 1;
                                m_blk[u] = chacha_block(build_state(m_key[u], m_ctr[u], m_nonce[u]));
                            end
                        end
                    end
                end
                if (seed_load[u]) model_reset(u, key[u], nonce[u]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int w0;
        clear = 1'b1;
        for (int u = 0; u < 2; u++) begin
            key[u] = '0; nonce[u] = '0; seed_load[u] = 1'b0;
            enable[u] = 1'b0; ready[u] = 1'b0;
            m_words[u] = 0; m_starts[u] = 0;
        end
        nclk();
        // reset state
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_word", word[0], 32'd0);
        chk("rst_start", 32'(bstart[0]), 32'd0);
        chk("rst_exh", 32'(exhausted[0]), 32'd0);
        chk("rst_fsm", 32'(dut_a.r_state), 32'(ST_IDLE));
        chk("rst_const0", bri[0][31:0], 32'h61707865);
        chk("rst_ctr_a", bri[0][415:384], 32'd1);
        chk("rst_ctr_b", bri[1][415:384], 32'hFFFF_FFFE);

        // RFC 8439 2.3.2 vector
        pclk();
        clear = 1'b0;
        for (int k = 0; k < 8; k++)
            key[0][32*k +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        nonce[0] = {32'h00000000, 32'h4a000000, 32'h09000000};
        seed_load[0] = 1'b1;
        pclk();
        seed_load[0] = 1'b0;
        enable[0] = 1'b1;
        for (int k = 0; k < 200 && !valid[0]; k++) nclk();
        chk("first_valid", 32'(valid[0]), 32'd1);
        chk("rfc_w0", word[0], 32'he4e7f110);

        // backpressure: first word held for 50 cycles
        for (int k = 0; k < 50; k++) begin
            nclk();
            chk("bp_word", word[0], 32'he4e7f110);
            chk("bp_valid", 32'(valid[0]), 32'd1);
        end
        chk("bp_fsm_done", 32'(dut_a.r_state), 32'(ST_DONE));
        chk("bp_ctr2", bri[0][415:384], 32'd2);
        chk("bp_starts", 32'(m_starts[0]), 32'd2);
        pclk();
        ready[0] = 1'b1;
        nclk();
        nclk();
        chk("rfc_w1", word[0], 32'h15593bd1);

        // random backpressure
        for (int k = 0; k < 400; k++) begin
            pclk();
            ready[0] = ($urandom_range(0, 3) != 0);
        end
        ready[0] = 1'b1;

        // counter wrap on the second DUT
        for (int k = 0; k < 8; k++) key[1][32*k +: 32] = $urandom();
        for (int k = 0; k < 3; k++) nonce[1][32*k +: 32] = $urandom();
        seed_load[1] = 1'b1;
        pclk();
        seed_load[1] = 1'b0;
        enable[1] = 1'b1;
        ready[1] = 1'b1;
        for (int k = 0; k < 300 && !exhausted[1]; k++) nclk();
        chk("wrap_exh_set", 32'(exhausted[1]), 32'd1);
        repeat (100) nclk();
        chk("wrap_words", 32'(m_words[1]), 32'd32);
        chk("wrap_starts", 32'(m_starts[1]), 32'd2);
        chk("wrap_exh_hold", 32'(exhausted[1]), 32'd1);
        chk("wrap_valid", 32'(valid[1]), 32'd0);
        pclk();
        seed_load[1] = 1'b1;
        pclk();
        seed_load[1] = 1'b0;
        nclk();
        nclk();
        chk("wrap_reseed_exh", 32'(exhausted[1]), 32'd0);
        w0 = m_words[1];
        for (int k = 0; k < 300 && m_words[1] < w0 + 16; k++) nclk();
        chk("wrap_relaunch", 32'(m_words[1] >= w0 + 16), 32'd1);
        enable[1] = 1'b0;

        // enable low: in-flight work drains, nothing new launches
        pclk();
        enable[0] = 1'b0;
        repeat (100) nclk();
        s0 = m_starts[0];
        repeat (60) nclk();
        chk("en_low_starts", 32'(m_starts[0]), 32'(s0));
        chk("en_low_valid", 32'(valid[0]), 32'd0);

        // reseed while BUSY
        pclk();
        enable[0] = 1'b1;
        for (int k = 0; k < 100 && bfin[0]; k++) nclk();
        chk("reseed_busy", 32'(bfin[0]), 32'd0);
        pclk();
        ready[0] = 1'b0;
        seed_load[0] = 1'b1;
        for (int k = 0; k < 8; k++) key[0][32*k +: 32] = $urandom();
        for (int k = 0; k < 3; k++) nonce[0][32*k +: 32] = $urandom();
        pclk();
        seed_load[0] = 1'b0;
        nclk();
        chk("reseed_valid", 32'(valid[0]), 32'd0);
        pclk();
        ready[0] = 1'b1;
        w0 = m_words[0];
        for (int k = 0; k < 600 && m_words[0] < w0 + 32; k++) nclk();
        chk("reseed_stream", 32'(m_words[0] >= w0 + 32), 32'd1);

        // asynchronous clear mid-drain at index 7
        for (int k = 0; k < 400 && !(valid[0] && dut_a.u_ser.r_index == 4'd7); k++) nclk();
        chk("clr_at_idx7", 32'(dut_a.u_ser.r_index), 32'd7);
        #1;
        clear = 1'b1;
        enable[0] = 1'b0;
        #1;
        chk("clr_valid", 32'(valid[0]), 32'd0);
        chk("clr_fsm", 32'(dut_a.r_state), 32'(ST_IDLE));
        chk("clr_word", word[0], 32'd0);
        @(negedge clock);
        pclk();
        clear = 1'b0;
        s0 = m_starts[0];
        repeat (20) nclk();
        chk("clr_no_launch", 32'(m_starts[0]), 32'(s0));
        chk("clr_seed_zero", 32'(bri[0][383:128] == 256'd0), 32'd1);
        chk("clr_ctr_init", bri[0][415:384], 32'd1);
        pclk();
        enable[0] = 1'b1;
        w0 = m_words[0];
        for (int k = 0; k < 300 && m_words[0] < w0 + 16; k++) nclk();
        chk("clr_restart", 32'(m_words[0] >= w0 + 16), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
